// File: rtl/prbs_lfsr_pkg.sv
// prbs_lfsr_pkg
//   Types and helpers shared by the PRBS generator (prbs_lfsr_gen) and its
//   optional self-synchronising checker (prbs_lfsr_chk).
//   - lfsr_mode_e : generator mode encoding as seen on mode_i
//   - chk_state_e : checker synchronisation state
//   - CHK_LOSS_N  : consecutive locked-state misses that force a re-hunt
//   - lfsr_fb()   : Fibonacci feedback with all-zero recovery
package prbs_lfsr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_RUN    = 2'b01,
        MODE_SLOAD  = 2'b10,
        MODE_RESEED = 2'b11
    } lfsr_mode_e;

    typedef enum logic {
        CHK_HUNT = 1'b0,
        CHK_LOCK = 1'b1
    } chk_state_e;

    localparam int unsigned CHK_LOSS_N = 4;

    // Operands are zero-extended to the widest legal LFSR so that one
    // function serves every WIDTH; the extra zero bits do not change the
    // parity nor the all-zero test.
    function automatic logic lfsr_fb(input logic [63:0] state, input logic [63:0] taps);
        return (^(state & taps)) | (state == 64'd0);
    endfunction

endpackage

// File: rtl/prbs_lfsr_chk.sv
// prbs_lfsr_chk
//   Self-synchronising PRBS checker. While hunting it loads the incoming
//   stream into its own reference register and waits for 2*WIDTH consecutive
//   correctly predicted bits; once locked the reference free-runs so each bad
//   input bit is counted exactly once. CHK_LOSS_N consecutive misses return
//   it to hunting. Everything is frozen on cycles without chk_vld_i.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   reset    | cr = 0, runs = 0, error count = 0, enters CHK_HUNT
//   CHK_HUNT | shift received bit into cr, count consecutive matches
//   CHK_LOCK | shift predicted bit into cr, count errors and miss run
//
// Ports
//   clk        in  1      rising-edge clock
//   rst_n      in  1      synchronous active-low reset
//   chk_vld_i  in  1      sample strobe
//   chk_i      in  1      received data bit
//   chk_lock_o out 1      checker locked
//   chk_err_o  out ERR_W  saturating mismatch count (cleared only by reset)
module prbs_lfsr_chk
    import prbs_lfsr_pkg::*;
#(
    parameter int unsigned     WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS = 32'hA300_0000,
    parameter int unsigned     ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chk_vld_i,
    input  logic             chk_i,
    output logic             chk_lock_o,
    output logic [ERR_W-1:0] chk_err_o
);

    localparam int unsigned RUN_W  = $clog2(2 * WIDTH);
    localparam int unsigned MISS_W = $clog2(CHK_LOSS_N);
    // Compared against the count before increment, so the transition fires
    // on the edge accepting the final sample.
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(2 * WIDTH - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(CHK_LOSS_N - 1);

    logic [WIDTH-1:0]  cr_q,   cr_d;
    chk_state_e        st_q,   st_d;
    logic [RUN_W-1:0]  run_q,  run_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [ERR_W-1:0]  err_q,  err_d;
    logic              pred;

    always_comb begin
        cr_d   = cr_q;
        st_d   = st_q;
        run_d  = run_q;
        miss_d = miss_q;
        err_d  = err_q;
        pred   = lfsr_fb(64'(cr_q), 64'(TAPS));

        if (chk_vld_i) begin
            if (st_q == CHK_HUNT) begin
                cr_d = {cr_q[WIDTH-2:0], chk_i};
                if (chk_i == pred) begin
                    if (run_q == RUN_LAST) begin
                        st_d   = CHK_LOCK;
                        run_d  = '0;
                        miss_d = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end else begin
                    run_d = '0;
                end
            end else begin
                cr_d = {cr_q[WIDTH-2:0], pred};
                if (chk_i != pred) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (miss_q == MISS_LAST) begin
                        st_d   = CHK_HUNT;
                        miss_d = '0;
                        run_d  = '0;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end else begin
                    miss_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cr_q   <= '0;
            st_q   <= CHK_HUNT;
            run_q  <= '0;
            miss_q <= '0;
            err_q  <= '0;
        end else begin
            cr_q   <= cr_d;
            st_q   <= st_d;
            run_q  <= run_d;
            miss_q <= miss_d;
            err_q  <= err_d;
        end
    end

    assign chk_lock_o = (st_q == CHK_LOCK);
    assign chk_err_o  = err_q;

endmodule

// File: rtl/prbs_lfsr_gen.sv
// prbs_lfsr_gen
//   Parametrised Fibonacci LFSR pattern generator. Shifts up (stage 0 is the
//   newest bit), supports hold, serial load, reseed, and re-injects a 1 when
//   running from the all-zero state. Build option PRBS_LFSR_CHECKER_EN adds
//   the self-synchronising checker and its four chk_* ports; without it the
//   generator behaves identically and the checker ports do not exist.
//
// Ports
//   clk        in  1      rising-edge clock
//   rst_n      in  1      synchronous active-low reset
//   mode_i     in  2      00 HOLD, 01 RUN, 10 SLOAD, 11 RESEED
//   ser_i      in  1      serial load bit (SLOAD)
//   state_o    out OUT_W  top OUT_W stages of the LFSR
//   ser_o      out 1      top stage of the LFSR
//   inj_o      out 1      pulse: zero-state recovery bit went in on last edge
//   chk_vld_i  in  1      checker sample strobe       (checker build only)
//   chk_i      in  1      checker data bit            (checker build only)
//   chk_lock_o out 1      checker locked              (checker build only)
//   chk_err_o  out ERR_W  checker mismatch count      (checker build only)
module prbs_lfsr_gen
    import prbs_lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = 32'hA300_0000,
    parameter logic [WIDTH-1:0] SEED  = 1,
    parameter int unsigned      OUT_W = 8,
    parameter int unsigned      ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode_i,
    input  logic             ser_i,
    output logic [OUT_W-1:0] state_o,
    output logic             ser_o,
    output logic             inj_o
`ifdef PRBS_LFSR_CHECKER_EN
    ,
    input  logic             chk_vld_i,
    input  logic             chk_i,
    output logic             chk_lock_o,
    output logic [ERR_W-1:0] chk_err_o
`endif
);

    lfsr_mode_e       mode;
    logic [WIDTH-1:0] state_q, state_d;
    logic             inj_q,   inj_d;
    logic             zero;

    assign mode = lfsr_mode_e'(mode_i);
    assign zero = (state_q == '0);

    always_comb begin
        state_d = state_q;
        inj_d   = 1'b0;
        unique case (mode)
            MODE_HOLD:   state_d = state_q;
            MODE_RUN: begin
                state_d = {state_q[WIDTH-2:0], lfsr_fb(64'(state_q), 64'(TAPS))};
                inj_d   = zero;
            end
            // Raw load: all-zero must stay loadable, so no recovery here.
            MODE_SLOAD:  state_d = {state_q[WIDTH-2:0], ser_i};
            MODE_RESEED: state_d = SEED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEED;
            inj_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inj_q   <= inj_d;
        end
    end

    assign state_o = state_q[WIDTH-1 -: OUT_W];
    assign ser_o   = state_q[WIDTH-1];
    assign inj_o   = inj_q;

`ifdef PRBS_LFSR_CHECKER_EN
    prbs_lfsr_chk #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .ERR_W (ERR_W)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .chk_vld_i  (chk_vld_i),
        .chk_i      (chk_i),
        .chk_lock_o (chk_lock_o),
        .chk_err_o  (chk_err_o)
    );
`endif

endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// tb_prbs_lfsr_gen
//   Self-checking bench for prbs_lfsr_gen with WIDTH=8, TAPS=8'hB8, SEED=8'h01,
//   OUT_W=8 and a narrow error counter so saturation is reachable. The
//   reference model works on whole byte values with arithmetic and popcount
//   parity. Checker scenarios are built only when PRBS_LFSR_CHECKER_EN is set.
module tb_prbs_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode_i;
    logic       ser_i;
    logic [7:0] state_o;
    logic       ser_o;
    logic       inj_o;
`ifdef PRBS_LFSR_CHECKER_EN
    logic       chk_vld_i;
    logic       chk_i;
    logic       chk_lock_o;
    logic [2:0] chk_err_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_state;
    logic       m_inj;
`ifdef PRBS_LFSR_CHECKER_EN
    logic [7:0] m_cr;
    bit         m_lock;
    int         m_run, m_miss, m_err;
`endif

    prbs_lfsr_gen #(
        .WIDTH (8),
        .TAPS  (8'hB8),
        .SEED  (8'h01),
        .OUT_W (8),
        .ERR_W (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_i     (mode_i),
        .ser_i      (ser_i),
        .state_o    (state_o),
        .ser_o      (ser_o),
        .inj_o      (inj_o)
`ifdef PRBS_LFSR_CHECKER_EN
        ,
        .chk_vld_i  (chk_vld_i),
        .chk_i      (chk_i),
        .chk_lock_o (chk_lock_o),
        .chk_err_o  (chk_err_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic ref_fb(input logic [7:0] s);
        return (($countones(s & 8'hB8) % 2) == 1) || (s == 8'h00);
    endfunction

    // Advance the model by the rules for the inputs currently applied, then
    // let the DUT take the same edge and settle.
    task automatic tick();
        logic [7:0] ns;
        logic       ni;
`ifdef PRBS_LFSR_CHECKER_EN
        logic       p;
`endif
        ns = m_state;
        ni = 1'b0;
        if (!rst_n) begin
            ns = 8'h01;
        end else if (mode_i == 2'd1) begin
            ns = 8'((m_state * 2) + ref_fb(m_state));
            ni = (m_state == 8'h00);
        end else if (mode_i == 2'd2) begin
            ns = 8'((m_state * 2) + ser_i);
        end else if (mode_i == 2'd3) begin
            ns = 8'h01;
        end
`ifdef PRBS_LFSR_CHECKER_EN
        if (!rst_n) begin
            m_cr = 8'h00; m_lock = 0; m_run = 0; m_miss = 0; m_err = 0;
        end else if (chk_vld_i) begin
            p = ref_fb(m_cr);
            if (!m_lock) begin
                m_cr = 8'((m_cr * 2) + chk_i);
                if (chk_i == p) begin
                    m_run = m_run + 1;
                    if (m_run == 16) begin
                        m_lock = 1;
                        m_run  = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                m_cr = 8'((m_cr * 2) + p);
                if (chk_i != p) begin
                    if (m_err < 7) m_err = m_err + 1;
                    m_miss = m_miss + 1;
                    if (m_miss == 4) begin
                        m_lock = 0;
                        m_miss = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
`endif
        m_state = ns;
        m_inj   = ni;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        mode_i = 2'd1;
        ser_i  = 1'b1;
`ifdef PRBS_LFSR_CHECKER_EN
        chk_vld_i = 1'b1;
        chk_i     = 1'b1;
`endif
        tick();
        tick();
        n_checks++;
        if (state_o !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_state: state_o=%02h expected 01", state_o);
        end
        n_checks++;
        if (inj_o !== 1'b0 || ser_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: inj_o=%b ser_o=%b expected 0 0", inj_o, ser_o);
        end
`ifdef PRBS_LFSR_CHECKER_EN
        n_checks++;
        if (chk_lock_o !== 1'b0 || chk_err_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_chk: lock=%b err=%0d expected 0 0", chk_lock_o, chk_err_o);
        end
        chk_vld_i = 1'b0;
        chk_i     = 1'b0;
`endif
        rst_n  = 1'b1;
        mode_i = 2'd0;
    endtask

    task automatic test_run_sequence();
        logic [7:0] exp_seq [4];
        int         steps;
        bit         saw_zero;
        exp_seq = '{8'h02, 8'h04, 8'h08, 8'h11};
        mode_i = 2'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (state_o !== exp_seq[i] || inj_o !== 1'b0) begin
                n_fail++;
                $display("FAIL run_first[%0d]: state_o=%02h inj_o=%b expected %02h 0",
                         i, state_o, inj_o, exp_seq[i]);
            end
        end
        steps    = 4;
        saw_zero = 0;
        while (state_o !== 8'h01 && steps < 300) begin
            tick();
            steps++;
            if (state_o === 8'h00) saw_zero = 1;
            n_checks++;
            if (state_o !== m_state || ser_o !== m_state[7]) begin
                n_fail++;
                $display("FAIL run_step[%0d]: state_o=%02h ser_o=%b expected %02h %b",
                         steps, state_o, ser_o, m_state, m_state[7]);
            end
        end
        n_checks++;
        if (steps != 255 || saw_zero) begin
            n_fail++;
            $display("FAIL run_period: steps=%0d zero_seen=%0d expected 255 0", steps, saw_zero);
        end
        mode_i = 2'd0;
    endtask

    task automatic test_sload_hold_reseed();
        logic [7:0] pat;
        pat    = 8'b1011_0010;
        mode_i = 2'd2;
        for (int i = 7; i >= 0; i--) begin
            ser_i = pat[i];
            tick();
        end
        n_checks++;
        if (state_o !== 8'hB2 || inj_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sload: state_o=%02h inj_o=%b expected b2 0", state_o, inj_o);
        end
        mode_i = 2'd0;
        ser_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (state_o !== 8'hB2) begin
                n_fail++;
                $display("FAIL hold[%0d]: state_o=%02h expected b2", i, state_o);
            end
        end
        mode_i = 2'd3;
        tick();
        n_checks++;
        if (state_o !== 8'h01) begin
            n_fail++;
            $display("FAIL reseed: state_o=%02h expected 01", state_o);
        end
        mode_i = 2'd0;
    endtask

    task automatic test_zero_inject();
        mode_i = 2'd2;
        ser_i  = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if (state_o !== 8'h00 || inj_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sload_zero: state_o=%02h inj_o=%b expected 00 0", state_o, inj_o);
        end
        mode_i = 2'd1;
        tick();
        n_checks++;
        if (state_o !== 8'h01 || inj_o !== 1'b1) begin
            n_fail++;
            $display("FAIL inject: state_o=%02h inj_o=%b expected 01 1", state_o, inj_o);
        end
        tick();
        n_checks++;
        if (state_o !== 8'h02 || inj_o !== 1'b0) begin
            n_fail++;
            $display("FAIL inject_pulse: state_o=%02h inj_o=%b expected 02 0", state_o, inj_o);
        end
        mode_i = 2'd0;
    endtask

    task automatic test_reset_mid_run();
        mode_i = 2'd1;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (state_o !== 8'h01 || inj_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: state_o=%02h inj_o=%b expected 01 0", state_o, inj_o);
        end
        rst_n  = 1'b1;
        mode_i = 2'd0;
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            r = int'($urandom_range(0, 9));
            mode_i = (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : (r < 9) ? 2'd0 : 2'd3;
            ser_i  = 1'($urandom_range(0, 1));
`ifdef PRBS_LFSR_CHECKER_EN
            chk_vld_i = ($urandom_range(0, 3) != 0);
            chk_i     = m_state[7] ^ ($urandom_range(0, 19) == 0);
`endif
            tick();
            n_checks++;
            if (state_o !== m_state || ser_o !== m_state[7] || inj_o !== m_inj) begin
                n_fail++;
                $display("FAIL random_gen[%0d]: state_o=%02h ser_o=%b inj_o=%b expected %02h %b %b",
                         i, state_o, ser_o, inj_o, m_state, m_state[7], m_inj);
            end
`ifdef PRBS_LFSR_CHECKER_EN
            n_checks++;
            if (chk_lock_o !== m_lock || chk_err_o !== 3'(m_err)) begin
                n_fail++;
                $display("FAIL random_chk[%0d]: lock=%b err=%0d expected %0d %0d",
                         i, chk_lock_o, chk_err_o, m_lock, m_err);
            end
`endif
        end
        rst_n  = 1'b1;
        mode_i = 2'd0;
    endtask

`ifdef PRBS_LFSR_CHECKER_EN
    task automatic test_chk_lock();
        int n;
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        mode_i    = 2'd1;
        chk_vld_i = 1'b1;
        n = 0;
        while (!m_lock && n < 100) begin
            chk_i = m_state[7];
            tick();
            n++;
            n_checks++;
            if (chk_lock_o !== m_lock) begin
                n_fail++;
                $display("FAIL lock_track[%0d]: lock=%b expected %0d", n, chk_lock_o, m_lock);
            end
        end
        n_checks++;
        if (chk_lock_o !== 1'b1 || chk_err_o !== 3'd0) begin
            n_fail++;
            $display("FAIL lock_acquire: lock=%b err=%0d after %0d samples expected 1 0",
                     chk_lock_o, chk_err_o, n);
        end
        chk_i = ~m_state[7];
        tick();
        n_checks++;
        if (chk_lock_o !== 1'b1 || chk_err_o !== 3'd1) begin
            n_fail++;
            $display("FAIL single_err: lock=%b err=%0d expected 1 1", chk_lock_o, chk_err_o);
        end
        chk_i = m_state[7];
        tick();
    endtask

    task automatic test_chk_loss();
        int n;
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        mode_i    = 2'd1;
        chk_vld_i = 1'b1;
        n = 0;
        while (!m_lock && n < 100) begin
            chk_i = m_state[7];
            tick();
            n++;
        end
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < 4; i++) begin
                chk_i = ~m_state[7];
                tick();
                n_checks++;
                if (chk_lock_o !== (i < 3)) begin
                    n_fail++;
                    $display("FAIL loss_lock[%0d.%0d]: lock=%b expected %0d",
                             round, i, chk_lock_o, (i < 3));
                end
            end
            n_checks++;
            if (chk_err_o !== ((round == 0) ? 3'd4 : 3'd7)) begin
                n_fail++;
                $display("FAIL loss_count[%0d]: err=%0d expected %0d",
                         round, chk_err_o, (round == 0) ? 4 : 7);
            end
            n = 0;
            while (chk_lock_o !== 1'b1 && n < 100) begin
                chk_i = m_state[7];
                tick();
                n++;
            end
            n_checks++;
            if (n != 16 || chk_err_o !== ((round == 0) ? 3'd4 : 3'd7)) begin
                n_fail++;
                $display("FAIL relock[%0d]: samples=%0d err=%0d expected 16 %0d",
                         round, n, chk_err_o, (round == 0) ? 4 : 7);
            end
        end
    endtask

    task automatic test_chk_freeze_reset();
        chk_vld_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_i = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (chk_lock_o !== 1'b1 || chk_err_o !== 3'd7) begin
                n_fail++;
                $display("FAIL freeze[%0d]: lock=%b err=%0d expected 1 7", i, chk_lock_o, chk_err_o);
            end
        end
        chk_vld_i = 1'b1;
        chk_i     = m_state[7];
        rst_n     = 1'b0;
        tick();
        n_checks++;
        if (state_o !== 8'h01 || chk_lock_o !== 1'b0 || chk_err_o !== 3'd0) begin
            n_fail++;
            $display("FAIL chk_reset: state_o=%02h lock=%b err=%0d expected 01 0 0",
                     state_o, chk_lock_o, chk_err_o);
        end
        rst_n     = 1'b1;
        chk_vld_i = 1'b0;
        mode_i    = 2'd0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_state = 8'h01;
        m_inj   = 1'b0;
`ifdef PRBS_LFSR_CHECKER_EN
        m_cr = 8'h00; m_lock = 0; m_run = 0; m_miss = 0; m_err = 0;
`endif
        test_reset();
        test_run_sequence();
        test_sload_hold_reseed();
        test_zero_inject();
        test_reset_mid_run();
`ifdef PRBS_LFSR_CHECKER_EN
        test_chk_lock();
        test_chk_loss();
        test_chk_freeze_reset();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
